// File: rtl/sipo_rx.sv
// sipo_rx: serial-in / parallel-out receiver with a one-word holding register.
// Bits shift into sh on ser_en; a completed word moves to op if the holding
// register is free (or being drained this cycle), otherwise it is dropped
// and the sticky overrun flag is raised.
module sipo_rx #(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_a,
  input  logic                     ser_en,
  input  logic                     ser_in,
  input  logic                     dir,
  input  logic                     clr,
  input  logic                     op_ready,
  output logic [WIDTH-1:0]         op,
  output logic                     op_valid,
  output logic                     overrun,
  output logic [$clog2(WIDTH)-1:0] bit_cnt
);

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] r_sh;
  logic [CW-1:0]    r_cnt;
  logic             r_dir;       // latched order for the word in flight, 1 = LSB-first
  logic [WIDTH-1:0] r_op;
  logic             r_op_valid;
  logic             r_overrun;

  logic             w_first;
  logic             w_dir;
  logic             w_shift;
  logic             w_done;
  logic             w_load;
  logic             w_drop;
  logic [WIDTH-1:0] w_sh_nxt;

  // Bit 0 of a word uses the live dir input; later bits use the latched copy
  // so mid-word dir changes cannot scramble the word.
  always_comb begin
    w_first  = (r_cnt == '0);
    w_dir    = w_first ? dir : r_dir;
    w_sh_nxt = w_dir ? {ser_in, r_sh[WIDTH-1:1]} : {r_sh[WIDTH-2:0], ser_in};
    w_shift  = ser_en & ~clr;                 // clr wins over ser_en
    w_done   = w_shift & (r_cnt == LAST);
    w_load   = w_done & (~r_op_valid | op_ready);
    w_drop   = w_done & r_op_valid & ~op_ready;
  end

  // Shift register, bit counter and latched bit order.
  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      r_sh  <= '0;
      r_cnt <= '0;
      r_dir <= 1'b0;
    end else if (clr) begin
      r_sh  <= '0;
      r_cnt <= '0;
    end else if (ser_en) begin
      r_sh  <= w_sh_nxt;
      r_cnt <= w_done ? '0 : r_cnt + 1'b1;
      if (w_first) r_dir <= dir;
    end
  end

  // Holding register handshake; clr does not touch it.
  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      r_op       <= '0;
      r_op_valid <= 1'b0;
    end else if (w_load) begin
      r_op       <= w_sh_nxt;
      r_op_valid <= 1'b1;
    end else if (r_op_valid && op_ready) begin
      r_op_valid <= 1'b0;
    end
  end

  // Sticky overrun: set on a dropped word, cleared only by clr or reset.
  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a)      r_overrun <= 1'b0;
    else if (clr)    r_overrun <= 1'b0;
    else if (w_drop) r_overrun <= 1'b1;
  end

  assign op       = r_op;
  assign op_valid = r_op_valid;
  assign overrun  = r_overrun;
  assign bit_cnt  = r_cnt;

endmodule

// File: tb/tb_sipo_rx.sv
// Directed bench for sipo_rx (WIDTH=8): a table of words plus hand-written
// sequences for overrun, load-while-draining, clr abort and async reset.
module tb_sipo_rx;

  logic       clk = 1'b0;
  logic       rst_a, ser_en, ser_in, dir, clr, op_ready;
  logic [7:0] op;
  logic       op_valid, overrun;
  logic [2:0] bit_cnt;

  int total = 0;
  int bad   = 0;

  sipo_rx #(.WIDTH(8)) dut (
    .clk(clk), .rst_a(rst_a), .ser_en(ser_en), .ser_in(ser_in), .dir(dir),
    .clr(clr), .op_ready(op_ready), .op(op), .op_valid(op_valid),
    .overrun(overrun), .bit_cnt(bit_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       d;      // bit order for the word
    logic [7:0] seq;    // seq[7] is sent first
    int         gap;    // idle cycles between bits
    logic [7:0] exp;    // hand-computed op
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // One clock edge; returns 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [7:0] seq, input logic d, input int gap);
    for (int i = 7; i >= 0; i--) begin
      ser_en = 1'b1; ser_in = seq[i]; dir = d;
      tick();
      ser_en = 1'b0;
      for (int g = 0; g < gap && i > 0; g++) tick();
    end
  endtask

  task automatic consume();
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
  endtask

  initial begin
    vt[0] = '{1'b0, 8'hB2, 0, 8'hB2};
    vt[1] = '{1'b1, 8'hB2, 0, 8'h4D};
    vt[2] = '{1'b0, 8'h3C, 0, 8'h3C};
    vt[3] = '{1'b1, 8'h01, 0, 8'h80};
    vt[4] = '{1'b1, 8'hC0, 2, 8'h03};
    vt[5] = '{1'b0, 8'hFF, 1, 8'hFF};
    vt[6] = '{1'b0, 8'h00, 0, 8'h00};
    vt[7] = '{1'b1, 8'h6E, 0, 8'h76};

    rst_a = 1'b0; ser_en = 0; ser_in = 0; dir = 0; clr = 0; op_ready = 0;
    #12;
    chk("rst_op", op, 0);
    chk("rst_valid", op_valid, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_cnt", bit_cnt, 0);
    tick();
    rst_a = 1'b1;
    tick();

    // table: word, check partial count, check load, then drain
    for (int v = 0; v < 8; v++) begin
      for (int i = 7; i >= 1; i--) begin
        ser_en = 1'b1; ser_in = vt[v].seq[i]; dir = vt[v].d;
        tick();
        ser_en = 1'b0;
        for (int g = 0; g < vt[v].gap; g++) tick();
      end
      chk($sformatf("v%0d_cnt7", v), bit_cnt, 7);
      chk($sformatf("v%0d_nv", v), op_valid, 0);
      ser_en = 1'b1; ser_in = vt[v].seq[0];
      tick();
      ser_en = 1'b0;
      chk($sformatf("v%0d_op", v), op, vt[v].exp);
      chk($sformatf("v%0d_valid", v), op_valid, 1);
      chk($sformatf("v%0d_cnt0", v), bit_cnt, 0);
      consume();
      chk($sformatf("v%0d_drained", v), op_valid, 0);
      chk($sformatf("v%0d_hold", v), op, vt[v].exp);
    end

    // dir latched at bit 0; toggling after bit 3 is ignored
    for (int i = 7; i >= 0; i--) begin
      ser_en = 1'b1; ser_in = vt[1].seq[i];
      dir = (i > 4) ? 1'b1 : 1'b0;
      tick();
    end
    ser_en = 1'b0;
    chk("dirtog_op", op, 8'h4D);
    consume();

    // overrun: second word dropped while op is held
    send_word(8'hB2, 1'b0, 0);
    send_word(8'h3C, 1'b0, 0);
    chk("ovr_op", op, 8'hB2);
    chk("ovr_valid", op_valid, 1);
    chk("ovr_flag", overrun, 1);
    tick(); tick();
    chk("ovr_sticky", overrun, 1);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("clr_ovr", overrun, 0);
    chk("clr_op", op, 8'hB2);
    chk("clr_valid", op_valid, 1);
    // handshake still drains during clr
    clr = 1'b1; op_ready = 1'b1; tick(); clr = 1'b0; op_ready = 1'b0;
    chk("clr_drain", op_valid, 0);

    // word completes in the same cycle the held word is drained
    send_word(8'hB2, 1'b0, 0);
    for (int i = 7; i >= 0; i--) begin
      ser_en = 1'b1; ser_in = vt[2].seq[i]; dir = 1'b0;
      op_ready = (i == 0);
      tick();
    end
    ser_en = 1'b0; op_ready = 1'b0;
    chk("swap_op", op, 8'h3C);
    chk("swap_valid", op_valid, 1);
    chk("swap_ovr", overrun, 0);
    consume();

    // back-to-back words with op_ready held high
    op_ready = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      ser_en = 1'b1; ser_in = vt[0].seq[i]; dir = 1'b0; tick();
    end
    chk("b2b_first", op, 8'hB2);
    for (int i = 7; i >= 0; i--) begin
      ser_en = 1'b1; ser_in = vt[2].seq[i]; tick();
    end
    ser_en = 1'b0;
    chk("b2b_second", op, 8'h3C);
    chk("b2b_valid", op_valid, 1);
    tick();
    op_ready = 1'b0;
    chk("b2b_ovr", overrun, 0);

    // clr aborts a partial word, with priority over ser_en
    for (int i = 0; i < 3; i++) begin
      ser_en = 1'b1; ser_in = 1'b1; tick();
    end
    chk("abort_cnt3", bit_cnt, 3);
    clr = 1'b1; tick(); clr = 1'b0; ser_en = 1'b0;
    chk("abort_cnt0", bit_cnt, 0);
    send_word(8'hA5, 1'b0, 0);
    chk("abort_op", op, 8'hA5);
    consume();

    // async reset mid-word, between edges
    send_word(8'h3C, 1'b0, 0);
    for (int i = 0; i < 5; i++) begin
      ser_en = 1'b1; ser_in = 1'b1; dir = 1'b1; tick();
    end
    ser_en = 1'b0;
    chk("pre_rst_cnt", bit_cnt, 5);
    #2 rst_a = 1'b0;
    #1;
    chk("arst_op", op, 0);
    chk("arst_valid", op_valid, 0);
    chk("arst_cnt", bit_cnt, 0);
    tick();
    rst_a = 1'b1;
    send_word(8'h81, 1'b0, 0);
    chk("post_rst_op", op, 8'h81);
    chk("post_rst_valid", op_valid, 1);
    chk("post_rst_ovr", overrun, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sipo_rx.md
SIPO_RX -- requirements
Module: sipo_rx

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the deserialized word width in bits (minimum 2).
REQ-002 SHALL have port clk  input  1  meaning the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port rst_a  input  1  meaning the reset; asynchronous and active-low.
REQ-004 SHALL have port ser_en  input  1  meaning ser_in carries a valid bit this cycle.
REQ-005 SHALL have port ser_in  input  1  meaning the serial data bit.
REQ-006 SHALL have port dir  input  1  meaning bit order: 0 = MSB-first (shift left in), 1 = LSB-first (shift right in).
REQ-007 SHALL have port clr  input  1  meaning synchronous abort of the partially received word.
REQ-008 SHALL have port op_ready  input  1  meaning the consumer accepts op this cycle.
REQ-009 SHALL have port op  output  WIDTH  meaning the assembled parallel word (holding register).
REQ-010 SHALL have port op_valid  output  1  meaning op holds an unconsumed word.
REQ-011 SHALL have port overrun  output  1  meaning sticky flag: a completed word was dropped.
REQ-012 SHALL have port bit_cnt  output  clog2(WIDTH)  meaning the number of bits of the current word received so far.

Function
REQ-013 SHALL keep an internal shift register sh[WIDTH-1:0] and a bit counter; bit_cnt SHALL equal the counter.
REQ-014 SHALL sample dir on the ser_en cycle where bit_cnt==0 and SHALL use that latched order for the whole word; dir changes mid-word SHALL be ignored.
REQ-015 MSB-first, on ser_en: sh <= {sh[WIDTH-2:0], ser_in}.
REQ-016 LSB-first, on ser_en: sh <= {ser_in, sh[WIDTH-1:1]}.
REQ-017 When ser_en is low, sh and the counter SHALL hold.
REQ-018 On the ser_en cycle where bit_cnt==WIDTH-1, the word SHALL be complete: the counter SHALL wrap to 0 and the new sh value SHALL be the completed word.
REQ-019 A completed word SHALL be written to op, with op_valid=1 on the next cycle (1-cycle latency after the last bit), if op_valid==0 or (op_valid && op_ready) that same cycle.
REQ-020 Otherwise (op_valid==1, op_ready==0), the completed word SHALL be discarded, op SHALL be unchanged, and overrun SHALL set to 1.
REQ-021 op_valid SHALL clear the cycle after op_valid && op_ready, unless a completed word loads in that same cycle (REQ-019).
REQ-022 op SHALL change only on a word load; it SHALL hold its value while op_valid==0.
REQ-023 clr SHALL have priority over ser_en.
REQ-024 clr SHALL zero sh, the counter, and overrun on the next edge.
REQ-025 clr SHALL leave op and op_valid unaffected, and the op_ready handshake SHALL proceed normally during clr.
REQ-026 overrun SHALL remain set until clr or reset.
REQ-027 Reception SHALL be continuous: back-to-back ser_en strobes across word boundaries SHALL lose no bits.

Reset
REQ-028 While rst_a==0, sh, the counter, op, op_valid, and overrun SHALL be 0 immediately, regardless of clk.
REQ-029 Reset asserted mid-word SHALL discard the partial word; the first ser_en after release SHALL be bit 0.
REQ-030 The latched bit order SHALL reset to MSB-first.

Verification
REQ-031 dir=0, WIDTH=8, ser_in 1,0,1,1,0,0,1,0 on consecutive ser_en -> op=8'hB2, op_valid=1 one cycle after the 8th bit, bit_cnt=0.
REQ-032 dir=1, same bit sequence -> op=8'h4D; toggling dir after bit 3 -> still 8'h4D.
REQ-033 op_ready=0, two words 8'hB2 then 8'h3C -> op=8'hB2, op_valid=1, overrun=1; clr -> overrun=0, op=8'hB2 still.
REQ-034 op_valid=1 (8'hB2), second word 8'h3C completes with op_ready=1 in the same cycle -> op=8'h3C, op_valid stays 1, overrun=0.
REQ-035 3 bits received, then clr, then 8 bits of 8'hA5 MSB-first -> op=8'hA5; the 3 aborted bits are absent.
REQ-036 rst_a=0 between clock edges after 5 bits -> all outputs 0 immediately; after release, 8 bits of 8'h81 -> op=8'h81.
